// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: derives the game tick, picks a mole per round,
// judges button presses and keeps score/miss/round counts until the game ends.
module mole_round_ctrl #(
  parameter int unsigned CLK_DIV    = 2600000,
  parameter int unsigned N_MOLES    = 4,
  parameter int unsigned SHOW_TICKS = 10,
  parameter int unsigned GAP_TICKS  = 5,
  parameter int unsigned ROUNDS     = 16,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_MOLES-1:0] btn,
  output logic [N_MOLES-1:0] mole_led,
  output logic [7:0]         score,
  output logic [7:0]         misses,
  output logic [7:0]         round,
  output logic               busy,
  output logic               game_over
);

  localparam int unsigned SEL_W = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;
  localparam int unsigned PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [7:0]    SHOW_LAST  = 8'(SHOW_TICKS - 1);
  localparam logic [7:0]    GAP_LAST   = 8'(GAP_TICKS - 1);
  localparam logic [7:0]    ROUNDS_8   = 8'(ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  state_e             state_q;
  logic [PW-1:0]      presc_q;
  logic [7:0]         tick_cnt_q;
  logic [7:0]         lfsr_q;
  logic [7:0]         lfsr_d;
  logic [N_MOLES-1:0] btn_q;
  logic [SEL_W-1:0]   prev_sel_q;
  logic [N_MOLES-1:0] mole_led_q;
  logic [7:0]         score_q;
  logic [7:0]         misses_q;
  logic [7:0]         round_q;
  logic               busy_q;
  logic               game_over_q;

  logic [N_MOLES-1:0] press;
  logic               any_press;
  logic               hit;
  logic               tick;
  logic               show_done;
  logic               gap_done;
  logic [SEL_W-1:0]   cand;
  logic [SEL_W-1:0]   new_sel;

  // One-hot LED pattern for a mole index.
  function automatic logic [N_MOLES-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_MOLES-1:0] v;
    v = '0;
    for (int i = 0; i < int'(N_MOLES); i++) begin
      if (idx == SEL_W'(i)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // x^8+x^6+x^5+x^4+1 Fibonacci step.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Rising edges only; the mole currently lit is the last one selected.
  assign press     = btn & ~btn_q;
  assign any_press = |press;
  assign hit       = press[prev_sel_q];

  // The prescaler only runs inside a round, so ticks exist only in SHOW/GAP.
  assign tick      = ((state_q == ST_SHOW) || (state_q == ST_GAP)) && (presc_q == PRESC_LAST);
  assign show_done = tick && (tick_cnt_q == SHOW_LAST);
  assign gap_done  = tick && (tick_cnt_q == GAP_LAST);

  // Bump the candidate when it repeats the previous mole (wraps via SEL_W bits).
  assign cand    = lfsr_q[SEL_W-1:0];
  assign new_sel = (cand == prev_sel_q) ? (cand + SEL_W'(1)) : cand;

  assign mole_led  = mole_led_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign round     = round_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;

  // Game FSM with prescaler, tick counter, LFSR, button history and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      tick_cnt_q  <= 8'd0;
      lfsr_q      <= LFSR_SEED;
      btn_q       <= '1;
      prev_sel_q  <= '0;
      mole_led_q  <= '0;
      score_q     <= 8'd0;
      misses_q    <= 8'd0;
      round_q     <= 8'd0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      btn_q  <= btn;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          presc_q    <= '0;
          tick_cnt_q <= 8'd0;
          if (start) begin
            state_q     <= ST_SHOW;
            score_q     <= 8'd0;
            misses_q    <= 8'd0;
            round_q     <= 8'd0;
            prev_sel_q  <= new_sel;
            mole_led_q  <= onehot(new_sel);
            busy_q      <= 1'b1;
            game_over_q <= 1'b0;
          end
        end
        ST_SHOW: begin
          if (any_press || show_done) begin
            // A press on the final-tick cycle is judged as a press.
            state_q    <= ST_GAP;
            presc_q    <= '0;
            tick_cnt_q <= 8'd0;
            mole_led_q <= '0;
            round_q    <= round_q + 8'd1;
            if (hit) begin
              score_q <= score_q + 8'd1;
            end else begin
              misses_q <= misses_q + 8'd1;
            end
          end else if (tick) begin
            presc_q    <= '0;
            tick_cnt_q <= tick_cnt_q + 8'd1;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            presc_q    <= '0;
            tick_cnt_q <= 8'd0;
            if (round_q == ROUNDS_8) begin
              state_q     <= ST_OVER;
              busy_q      <= 1'b0;
              game_over_q <= 1'b1;
            end else begin
              state_q    <= ST_SHOW;
              prev_sel_q <= new_sel;
              mole_led_q <= onehot(new_sel);
            end
          end else if (tick) begin
            presc_q    <= '0;
            tick_cnt_q <= tick_cnt_q + 8'd1;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          presc_q     <= '0;
          tick_cnt_q  <= 8'd0;
          mole_led_q  <= '0;
          busy_q      <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mole_round_ctrl.md
Name: mole_round_ctrl

Overview:
Game sequencer for the whack-a-mole datapath. It derives the game tick from the system clock and picks a pseudo-random mole for each round. It lights that mole for a bounded window and judges the button presses. It also keeps score, miss and round counts and ends the game after a fixed number of rounds. It sits between the debounced button inputs and the LED/score display logic.

Parameters:
CLK_DIV, 2600000, system clocks per game tick (10 Hz at 26 MHz); legal range 2..2^25.
N_MOLES, 4, number of moles/buttons; power of two, 2..8.
SHOW_TICKS, 10, ticks a mole stays lit before a timeout miss; legal range 1..255.
GAP_TICKS, 5, ticks of dark gap between rounds; legal range 1..255.
ROUNDS, 16, rounds per game; legal range 1..255.
LFSR_SEED, 8'hA5, LFSR reset value; must be non-zero.

Ports:
clk  in  1  system clock, all state on posedge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle start pulse.
btn  in  N_MOLES  debounced button levels, synchronous to clk, 1 = pressed.
mole_led  out  N_MOLES  one-hot lit mole; 0 when no mole is lit.
score  out  8  hits this game.
misses  out  8  timeouts plus wrong presses this game.
round  out  8  completed rounds this game.
busy  out  1  high in SHOW or GAP.
game_over  out  1  high in OVER.

Behaviour:
- Reset (reset=0, async): state IDLE; mole_led=0, score=0, misses=0, round=0, busy=0, game_over=0.
  - Prescaler=0, tick counter=0, lfsr=LFSR_SEED, btn_q=all ones, prev_sel=0.
- Tick generation:
  - Prescaler counts 0..CLK_DIV-1 and emits a 1-cycle tick on the cycle it equals CLK_DIV-1, then wraps to 0.
  - Prescaler is held at 0 in IDLE and OVER, and cleared on every state entry, so the first tick comes exactly CLK_DIV cycles after entry.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clk cycle in all states.
  - Candidate = lfsr[log2(N_MOLES)-1:0]. If candidate == prev_sel, the selection is (candidate+1) mod N_MOLES. Never the same mole twice in a row, including across games.
- Edge detect: press[i] = btn[i] & ~btn_q[i]; btn_q <= btn every cycle. A button held through reset or start produces no press.
- FSM, registered, one transition per cycle max:
  - IDLE: start=1 -> SHOW at next edge. Clear score/misses/round, select a mole, and drive mole_led one-hot on the same edge.
  - SHOW, judged each cycle in priority order:
    - Correct press (press[sel]) -> GAP: score+1, round+1. Counts as a hit even if wrong buttons are pressed in the same cycle.
    - Any other press -> GAP: misses+1, round+1.
    - Tick count reaches SHOW_TICKS -> GAP: misses+1, round+1.
    - On any exit, mole_led=0 on the same edge.
    - A press on the cycle the final tick arrives counts as press, not timeout.
  - GAP: presses ignored. After GAP_TICKS ticks:
    - round==ROUNDS -> OVER.
    - Otherwise -> SHOW with a new mole selected on that edge.
  - OVER: game_over=1; score, misses and round held. start=1 -> SHOW, with the same clearing as from IDLE.
  - start is ignored in SHOW and GAP.
- Latency: start at edge t -> mole_led valid after edge t+1. Press sampled at edge t -> score/misses/round and mole_led=0 updated after edge t+1.
- Invariant: score+misses==round at all times. Counters cannot overflow (ROUNDS ≤ 255).
- Reset mid-game: immediate return to IDLE with all reset values.

Test Plan:
- CLK_DIV=4, SHOW_TICKS=3, GAP_TICKS=2, ROUNDS=2, no buttons; pulse start -> mole_led lit 12 cycles after the start edge, then dark 8, then lit 12. game_over=1, score=0, misses=2, round=2.
- Correct btn pulse 2 cycles after mole_led lights -> mole_led=0 and score=1 next cycle. Next mole differs from the previous one.
- Wrong button pressed together with the correct button in one cycle -> score+1, misses unchanged. Wrong button alone -> misses+1.
- Button held high across start -> no hit counted. Release then re-press -> hit.
- reset asserted low mid-SHOW, asynchronously between edges -> all outputs 0 immediately. start after release -> new game with score=0.
- In OVER with score=1, misses=1, pulse start -> counters clear to 0, SHOW entered, game_over=0 next cycle. start pulsed during SHOW/GAP -> no effect.
